// File: rtl/sprite_renderer_if.sv
// sprite_renderer_if: sprite request, sprite ROM port and LCD pixel-write handshake
interface sprite_renderer_if;
    logic        draw;
    logic [7:0]  xSprite;
    logic [8:0]  ySprite;
    logic [3:0]  spriteId;
    logic [13:0] romAddr;
    logic [15:0] romData;
    logic        pixelWrite;
    logic        pixelReady;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        busy;
    logic        done;
    modport master (
        input  draw, xSprite, ySprite, spriteId, romData, pixelReady,
        output romAddr, pixelWrite, xAddr, yAddr, pixelData, busy, done
    );
    modport slave (
        output draw, xSprite, ySprite, spriteId, romData, pixelReady,
        input  romAddr, pixelWrite, xAddr, yAddr, pixelData, busy, done
    );
endinterface

// File: rtl/sprite_renderer.sv
// sprite_renderer: scans a sprite box from ROM, writes opaque on-screen pixels to the LCD
// Optional SPRITE_RENDERER_ERASE_EN: first erase the previous sprite box with BG_COLOUR
module sprite_renderer #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          SCREEN_W    = 240,
    parameter int          SCREEN_H    = 320,
    parameter logic [15:0] TRANSPARENT = 16'hF81F,
    parameter logic [15:0] BG_COLOUR   = 16'h0000
) (
    input logic               clock,
    input logic               reset,
    sprite_renderer_if.master bus
);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam logic [CW-1:0] COL_MAX = CW'(SPRITE_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(SPRITE_H - 1);
    localparam logic [9:0] SW = 10'(SCREEN_W);
    localparam logic [9:0] SH = 10'(SCREEN_H);
    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, EVAL = 3'd2, WRITE = 3'd3, ADVANCE = 3'd4, DONE = 3'd5;
`ifdef SPRITE_RENDERER_ERASE_EN
    localparam logic [2:0] ERASE = 3'd6;
`endif
    logic [2:0]    state;
    logic [7:0]    x0;
    logic [8:0]    y0;
    logic [3:0]    id;
    logic [RW-1:0] row, row_next;
    logic [CW-1:0] col, col_next;
    logic [7:0]    bx;
    logic [8:0]    by;
    logic [9:0]    px, py;
    logic [15:0]   colour;
    logic          erasing, skip, last_col, last;
`ifdef SPRITE_RENDERER_ERASE_EN
    logic [7:0]    px0;
    logic [8:0]    py0;
    logic          prev_valid;
    always_comb begin
        bx = erasing ? px0 : x0;
        by = erasing ? py0 : y0;
    end
`else
    always_comb begin
        erasing = 1'b0;
        bx = x0;
        by = y0;
    end
`endif
    // 10-bit sums so a box hanging past the screen edge is clipped, not wrapped
    always_comb begin
        px = {2'b0, bx} + 10'(col);
        py = {1'b0, by} + 10'(row);
        colour = erasing ? BG_COLOUR : bus.romData;
        skip = (!erasing && bus.romData == TRANSPARENT) || px >= SW || py >= SH;
        last_col = col == COL_MAX;
        last = last_col && row == ROW_MAX;
        col_next = col + CW'(1);
        row_next = last_col ? row + RW'(1) : row;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            row <= '0;
            col <= '0;
            x0 <= '0;
            y0 <= '0;
            id <= '0;
            bus.romAddr <= '0;
            bus.pixelWrite <= 1'b0;
            bus.xAddr <= '0;
            bus.yAddr <= '0;
            bus.pixelData <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
`ifdef SPRITE_RENDERER_ERASE_EN
            erasing <= 1'b0;
            prev_valid <= 1'b0;
            px0 <= '0;
            py0 <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.draw) begin
                    x0 <= bus.xSprite;
                    y0 <= bus.ySprite;
                    id <= bus.spriteId;
                    row <= '0;
                    col <= '0;
                    bus.romAddr <= 14'({bus.spriteId, {RW{1'b0}}, {CW{1'b0}}});
                    bus.busy <= 1'b1;
`ifdef SPRITE_RENDERER_ERASE_EN
                    erasing <= prev_valid;
                    state <= prev_valid ? ERASE : FETCH;
`else
                    state <= FETCH;
`endif
                end
                FETCH: state <= EVAL;
`ifdef SPRITE_RENDERER_ERASE_EN
                EVAL, ERASE: begin
`else
                EVAL: begin
`endif
                    if (skip) state <= ADVANCE;
                    else begin
                        bus.xAddr <= px[7:0];
                        bus.yAddr <= py[8:0];
                        bus.pixelData <= colour;
                        bus.pixelWrite <= 1'b1;
                        state <= WRITE;
                    end
                end
                WRITE: if (bus.pixelReady) begin
                    bus.pixelWrite <= 1'b0;
                    state <= ADVANCE;
                end
                ADVANCE: begin
                    row <= row_next;
                    col <= col_next;
`ifdef SPRITE_RENDERER_ERASE_EN
                    // romAddr still points at (0,0) of the new sprite when the erase pass ends
                    if (erasing) begin
                        erasing <= !last;
                        state <= last ? FETCH : ERASE;
                    end else if (last) begin
                        px0 <= x0;
                        py0 <= y0;
                        prev_valid <= 1'b1;
                        bus.done <= 1'b1;
                        state <= DONE;
                    end else begin
                        bus.romAddr <= 14'({id, row_next, col_next});
                        state <= FETCH;
                    end
`else
                    if (last) begin
                        bus.done <= 1'b1;
                        state <= DONE;
                    end else begin
                        bus.romAddr <= 14'({id, row_next, col_next});
                        state <= FETCH;
                    end
`endif
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
